mips_hilo_muldiv: RTL and testbench
===================================

// Module: mips_hilo_muldiv
// PURPOSE
//  HI/LO special-register unit with an iterative multiply/divide engine; consumes decoder controls
//  (hi_write, lo_write, hi_select, lo_select, unsigned_div, unsigned_mult) plus rs/rt operands.
//  Services MTHI/MTLO in one cycle, runs MULT/MULTU/DIV/DIVU as multi-cycle ops, and drives busy
//  to stall the pipeline. hi_out/lo_out feed the write-back mux for MFHI/MFLO.
// PARAMETERS
//  DATA_WIDTH  32  operand/HI/LO width; iteration count = DATA_WIDTH
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           async active-low reset
//  issue          in   1           one-cycle pulse qualifying the controls below; one pulse per instruction
//  kill           in   1           abort the in-flight op (pipeline flush)
//  hi_write       in   1           HI write enable
//  lo_write       in   1           LO write enable
//  hi_select      in   2           00 hold, 01 rs (MTHI), 10 div, 11 mult
//  lo_select      in   2           same encoding for LO
//  unsigned_div   in   1           unsigned qualifier
//  unsigned_mult  in   1           unsigned qualifier
//  rs_data        in   DATA_WIDTH  operand A / MTHI-MTLO source
//  rt_data        in   DATA_WIDTH  operand B
//  busy           out  1           multi-cycle op in flight; pipeline must stall
//  hi_out         out  DATA_WIDTH  HI register
//  lo_out         out  DATA_WIDTH  LO register
// BEHAVIOUR
//  - Reset (async): HI=0, LO=0, busy=0, state=IDLE, iteration counter=0. Mid-op reset discards the op.
//  - Operation: taken from hi_select/lo_select; signedness is unsigned = unsigned_div | unsigned_mult.
//  - Issue acceptance: issue is accepted only in IDLE.
//    - issue while busy is ignored (bench asserts this never happens).
//    - issue with hi_write=lo_write=0 is a no-op.
//  - MTHI/MTLO (select 01): HI/LO <= rs_data at the issue edge; readable the next cycle; busy stays 0.
//  - FSM: IDLE -> ITER (DATA_WIDTH cycles) -> FIXUP (1 cycle) -> IDLE.
//    - DIV/MULT issue: latch |operands| and sign flags; busy=1 from cycle+1 through FIXUP (33 cycles).
//    - HI/LO are written at the FIXUP->IDLE edge; busy=0 that same cycle.
//  - MULT/MULTU: shift-add, one bit per cycle.
//    - 64-bit product; HI = product[63:32], LO = product[31:0].
//    - Signed: negate the product in FIXUP if the operand signs differ.
//  - DIV/DIVU: restoring, one quotient bit per cycle; LO = quotient, HI = remainder.
//    - Signed: quotient sign = signA ^ signB; remainder takes the dividend's sign.
//  - Divide by zero: LO = all ones, HI = dividend (rs_data).
//  - Signed overflow (-2^(W-1) / -1): LO = 0x80000000, HI = 0.
//  - kill: in ITER/FIXUP, return to IDLE next cycle with HI/LO unchanged and busy=0.
//    - kill together with issue in IDLE: the issue is dropped.
//  - hi_out/lo_out are pure register outputs and keep their old values while busy.
// CONFIGURATION
//  HILO_FAST_MULT_EN defined:
//    - MULT/MULTU use a single-cycle '*' (sign-extended to 2W bits).
//    - HI/LO are written at the issue edge; busy is never raised for multiplies.
//  Not defined: the iterative shift-add path above. DIV is always iterative.
// STRUCTURE
//  - mips_pkg additions:
//    - hilo_sel_t enum {HILO_HOLD=2'b00, HILO_RS=2'b01, HILO_DIV=2'b10, HILO_MULT=2'b11}
//    - muldiv_state_t {MD_IDLE, MD_ITER, MD_FIXUP}
//    - HILO_WIDTH = 32
//  - Sub-module mips_muldiv_iter: iteration datapath (accumulator, shift regs, counter).
//    The top level holds the FSM control, the HI/LO registers and the kill/issue arbitration.
// TESTING
//  1 MTHI rs=0xDEADBEEF -> hi_out=0xDEADBEEF next cycle, lo_out unchanged, busy never 1
//  2 DIV rs=-7, rt=2 -> busy exactly 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF
//  3 DIVU rs=0xFFFFFFFF, rt=0x10 -> LO=0x0FFFFFFF, HI=0xF
//  4 rs=0xFFFFFFFF, rt=2:
//    - MULT -> HI=0xFFFFFFFF, LO=0xFFFFFFFE
//    - MULTU -> HI=0x1, LO=0xFFFFFFFE
//    - run with and without HILO_FAST_MULT_EN
//  5 DIV 100/0 -> LO=0xFFFFFFFF, HI=100; DIV 0x80000000/-1 -> LO=0x80000000, HI=0
//  6 Abort cases:
//    - kill at iteration 10 of DIV -> busy=0 next cycle, HI/LO hold prior values
//    - rst_n low mid-MULT -> HI=LO=0, busy=0

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared HI/LO select codes, mul/div FSM states and data width
package mips_pkg;
    localparam int HILO_WIDTH = 32;
    typedef enum logic [1:0] {
        HILO_HOLD = 2'b00,
        HILO_RS   = 2'b01,
        HILO_DIV  = 2'b10,
        HILO_MULT = 2'b11
    } hilo_sel_t;
    typedef enum logic [1:0] {MD_IDLE, MD_ITER, MD_FIXUP} muldiv_state_t;
endpackage

// File: rtl/mips_muldiv_iter.sv
// mips_muldiv_iter: unsigned shift-add multiply / restoring divide datapath, one bit per step
module mips_muldiv_iter import mips_pkg::*; #(
    parameter int DATA_WIDTH = HILO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  step,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a_mag,
    input  logic [DATA_WIDTH-1:0] b_mag,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] acc_hi,
    output logic [DATA_WIDTH-1:0] acc_lo
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(W);

    logic [W-1:0]  b_r;
    logic [CW-1:0] cnt;
    logic [W:0]    sum, sh;
    logic [W-1:0]  diff;
    logic          ge;

    // multiply: acc_hi accumulates, acc_lo shifts out multiplier bits and shifts in product bits
    assign sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_r} : '0);
    // divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in
    assign sh   = {acc_hi, acc_lo[W-1]};
    assign ge   = sh >= {1'b0, b_r};
    assign diff = sh[W-1:0] - b_r;
    assign last = cnt == CW'(W - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi <= '0;
            acc_lo <= '0;
            b_r    <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc_hi <= '0;
            acc_lo <= a_mag;
            b_r    <= b_mag;
            cnt    <= '0;
        end else if (step) begin
            acc_hi <= is_div ? (ge ? diff : sh[W-1:0]) : sum[W:1];
            acc_lo <= is_div ? {acc_lo[W-2:0], ge} : {sum[0], acc_lo[W-1:1]};
            cnt    <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mips_hilo_muldiv.sv
// mips_hilo_muldiv: HI/LO registers with MTHI/MTLO and an iterative MULT/DIV engine.
// Define HILO_FAST_MULT_EN for single-cycle multiplies written at the issue edge.
module mips_hilo_muldiv import mips_pkg::*; #(
    parameter int DATA_WIDTH = HILO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue,
    input  logic                  kill,
    input  logic                  hi_write,
    input  logic                  lo_write,
    input  logic [1:0]            hi_select,
    input  logic [1:0]            lo_select,
    input  logic                  unsigned_div,
    input  logic                  unsigned_mult,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);
    localparam int W = DATA_WIDTH;

    muldiv_state_t  state;
    hilo_sel_t      hsel, lsel;
    logic           go, hi_md, lo_md, op_div_in, sgn, a_neg, b_neg, start, last;
    logic           op_div, wr_hi, wr_lo, neg_q, neg_r, div0;
    logic           hi_now_en, lo_now_en;
    logic [W-1:0]   hi_now, lo_now, a_mag, b_mag, acc_hi, acc_lo, rs_hold;
    logic [2*W-1:0] mag, res;

    assign hsel      = hilo_sel_t'(hi_select);
    assign lsel      = hilo_sel_t'(lo_select);
    assign go        = issue && !kill && state == MD_IDLE;
    assign hi_md     = hi_write && hi_select[1];
    assign lo_md     = lo_write && lo_select[1];
    assign op_div_in = hi_md ? hsel == HILO_DIV : lsel == HILO_DIV;
    assign sgn       = !(unsigned_div || unsigned_mult);
    assign a_neg     = sgn && rs_data[W-1];
    assign b_neg     = sgn && rt_data[W-1];
    assign a_mag     = a_neg ? -rs_data : rs_data;
    assign b_mag     = b_neg ? -rt_data : rt_data;

`ifdef HILO_FAST_MULT_EN
    logic [2*W-1:0] a_ext, b_ext, fast_prod;
    assign a_ext     = {{W{a_neg}}, rs_data};
    assign b_ext     = {{W{b_neg}}, rt_data};
    assign fast_prod = a_ext * b_ext;
    assign hi_now_en = go && hi_write && (hsel == HILO_RS || hsel == HILO_MULT);
    assign lo_now_en = go && lo_write && (lsel == HILO_RS || lsel == HILO_MULT);
    assign hi_now    = hsel == HILO_MULT ? fast_prod[2*W-1:W] : rs_data;
    assign lo_now    = lsel == HILO_MULT ? fast_prod[W-1:0] : rs_data;
    assign start     = go && (hi_md || lo_md) && op_div_in;
`else
    assign hi_now_en = go && hi_write && hsel == HILO_RS;
    assign lo_now_en = go && lo_write && lsel == HILO_RS;
    assign hi_now    = rs_data;
    assign lo_now    = rs_data;
    assign start     = go && (hi_md || lo_md);
`endif

    mips_muldiv_iter #(.DATA_WIDTH(W)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .step   (state == MD_ITER),
        .is_div (op_div),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .last   (last),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo)
    );

    // sign restoration; the -2^(W-1)/-1 case falls out naturally as quotient 2^(W-1), remainder 0
    assign mag = {acc_hi, acc_lo};
    assign res = op_div ? (div0 ? {rs_hold, {W{1'b1}}}
                                : {neg_r ? -acc_hi : acc_hi, neg_q ? -acc_lo : acc_lo})
                        : (neg_q ? -mag : mag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MD_IDLE;
            busy    <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
            op_div  <= 1'b0;
            wr_hi   <= 1'b0;
            wr_lo   <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0    <= 1'b0;
            rs_hold <= '0;
        end else begin
            if (hi_now_en) hi_out <= hi_now;
            if (lo_now_en) lo_out <= lo_now;
            if (start) begin
                state   <= MD_ITER;
                busy    <= 1'b1;
                op_div  <= op_div_in;
                wr_hi   <= hi_md;
                wr_lo   <= lo_md;
                neg_q   <= a_neg ^ b_neg;
                neg_r   <= a_neg;
                div0    <= rt_data == '0;
                rs_hold <= rs_data;
            end
            if (state == MD_ITER) begin
                state <= kill ? MD_IDLE : (last ? MD_FIXUP : MD_ITER);
                busy  <= !kill;
            end
            if (state == MD_FIXUP) begin
                state <= MD_IDLE;
                busy  <= 1'b0;
                if (!kill && wr_hi) hi_out <= res[2*W-1:W];
                if (!kill && wr_lo) lo_out <= res[W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_mips_hilo_muldiv.sv
// tb_mips_hilo_muldiv: directed and random checks of the HI/LO mul/div unit against an arithmetic model.
// Honors HILO_FAST_MULT_EN for expected multiply latency.
module tb_mips_hilo_muldiv;
    logic        clk = 1'b0, rst_n = 1'b0, issue = 1'b0, kill = 1'b0;
    logic        hi_write = 1'b0, lo_write = 1'b0, unsigned_div = 1'b0, unsigned_mult = 1'b0;
    logic [1:0]  hi_select = 2'b00, lo_select = 2'b00;
    logic [31:0] rs_data = '0, rt_data = '0, hi_out, lo_out;
    logic        busy;
    int          n_cmp = 0, n_err = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

`ifdef HILO_FAST_MULT_EN
    localparam int MUL_CYC = 0;
`else
    localparam int MUL_CYC = 33;
`endif

    always #5 clk = ~clk;

    mips_hilo_muldiv dut (
        .clk(clk), .rst_n(rst_n), .issue(issue), .kill(kill),
        .hi_write(hi_write), .lo_write(lo_write), .hi_select(hi_select), .lo_select(lo_select),
        .unsigned_div(unsigned_div), .unsigned_mult(unsigned_mult),
        .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .hi_out(hi_out), .lo_out(lo_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // {HI, LO} from plain integer arithmetic; Verilog / and % truncate toward zero like MIPS
    function automatic logic [63:0] ref_result(input bit is_div, input bit uns, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p, qv, rv;
        sa = uns ? longint'({32'b0, a}) : longint'($signed(a));
        sb = uns ? longint'({32'b0, b}) : longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            return p;
        end
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] sp [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
    endfunction

    task automatic run_op(input string tag, input logic hw, input logic lw, input logic [1:0] sel,
                          input logic ud, input logic um, input logic [31:0] a, input logic [31:0] b);
        int n, want_cyc;
        logic [63:0] r;
        hi_write = hw; lo_write = lw; hi_select = sel; lo_select = sel;
        unsigned_div = ud; unsigned_mult = um; rs_data = a; rt_data = b; issue = 1'b1;
        @(negedge clk);
        issue = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        want_cyc = ((hw || lw) && sel[1]) ? (sel == 2'b10 ? 33 : MUL_CYC) : 0;
        r = ref_result(sel == 2'b10, ud || um, a, b);
        if (hw) exp_hi = (sel == 2'b01) ? a : (sel[1] ? r[63:32] : exp_hi);
        if (lw) exp_lo = (sel == 2'b01) ? a : (sel[1] ? r[31:0] : exp_lo);
        check({tag, "_busy_cycles"}, 64'(n), 64'(want_cyc));
        check({tag, "_hi"}, {32'b0, hi_out}, {32'b0, exp_hi});
        check({tag, "_lo"}, {32'b0, lo_out}, {32'b0, exp_lo});
    endtask

    initial begin
        int k;
        logic hw, lw, coin;
        repeat (2) @(negedge clk);
        check("reset_hi", {32'b0, hi_out}, 64'h0);
        check("reset_lo", {32'b0, lo_out}, 64'h0);
        check("reset_busy", {63'b0, busy}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mthi", 1, 0, 2'b01, 0, 0, 32'hDEAD_BEEF, 32'h0);
        run_op("mtlo", 0, 1, 2'b01, 0, 0, 32'h1234_5678, 32'h0);
        run_op("div_m7_2", 1, 1, 2'b10, 0, 0, 32'hFFFF_FFF9, 32'h2);
        check("div_m7_2_lo_lit", {32'b0, lo_out}, 64'hFFFF_FFFD);
        check("div_m7_2_hi_lit", {32'b0, hi_out}, 64'hFFFF_FFFF);
        run_op("divu", 1, 1, 2'b10, 1, 0, 32'hFFFF_FFFF, 32'h10);
        run_op("mult", 1, 1, 2'b11, 0, 0, 32'hFFFF_FFFF, 32'h2);
        check("mult_hi_lit", {32'b0, hi_out}, 64'hFFFF_FFFF);
        run_op("multu", 1, 1, 2'b11, 0, 1, 32'hFFFF_FFFF, 32'h2);
        check("multu_hi_lit", {32'b0, hi_out}, 64'h1);
        run_op("div_by0", 1, 1, 2'b10, 0, 0, 32'd100, 32'h0);
        run_op("div_ovf", 1, 1, 2'b10, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo_lit", {32'b0, lo_out}, 64'h8000_0000);
        run_op("nop_issue", 0, 0, 2'b10, 0, 0, 32'h5, 32'h3);

        // kill during DIV iterations
        hi_write = 1; lo_write = 1; hi_select = 2'b10; lo_select = 2'b10;
        unsigned_div = 0; unsigned_mult = 0; rs_data = 32'd1000; rt_data = 32'd7; issue = 1;
        @(negedge clk);
        issue = 0; hi_write = 0; lo_write = 0;
        repeat (9) @(negedge clk);
        check("kill_pre_busy", {63'b0, busy}, 64'h1);
        kill = 1;
        @(negedge clk);
        kill = 0;
        check("kill_busy", {63'b0, busy}, 64'h0);
        repeat (40) @(negedge clk);
        check("kill_hi", {32'b0, hi_out}, {32'b0, exp_hi});
        check("kill_lo", {32'b0, lo_out}, {32'b0, exp_lo});

        // kill together with issue in IDLE drops the issue
        hi_write = 1; hi_select = 2'b01; rs_data = 32'hCAFE_F00D; issue = 1; kill = 1;
        @(negedge clk);
        issue = 0; kill = 0; hi_write = 0;
        check("kill_issue_hi", {32'b0, hi_out}, {32'b0, exp_hi});
        check("kill_issue_busy", {63'b0, busy}, 64'h0);

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 5);
            hw = 1'($urandom_range(0, 1));
            lw = hw ? 1'($urandom_range(0, 1)) : 1'b1;
            coin = 1'($urandom_range(0, 1));
            case (k)
                0: run_op("rnd_mt", hw, lw, 2'b01, 0, 0, pick(), pick());
                1, 2: run_op("rnd_div", hw, lw, 2'b10, coin & 1'($urandom_range(0, 1)), 0, pick(), pick());
                3, 4: run_op("rnd_mul", hw, lw, 2'b11, 0, coin & 1'($urandom_range(0, 1)), pick(), pick());
                default: run_op("rnd_nop", 0, 0, 2'($urandom_range(0, 3)), 0, 0, pick(), pick());
            endcase
        end

        // asynchronous reset in the middle of a MULT
        hi_write = 1; lo_write = 1; hi_select = 2'b11; lo_select = 2'b11;
        rs_data = 32'h1234_5678; rt_data = 32'h9ABC_DEF0; issue = 1;
        @(negedge clk);
        issue = 0; hi_write = 0; lo_write = 0;
        repeat (5) @(negedge clk);
        rst_n = 0;
        #1;
        check("rst_mid_hi", {32'b0, hi_out}, 64'h0);
        check("rst_mid_lo", {32'b0, lo_out}, 64'h0);
        check("rst_mid_busy", {63'b0, busy}, 64'h0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        run_op("post_rst_div", 1, 1, 2'b10, 0, 0, 32'd77, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
